// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP add/sub/compare issue stage.
package fpu_pkg;

   typedef enum logic [2:0] {
      OP_FADD = 3'd0,
      OP_FSUB = 3'd1,
      OP_FEQ  = 3'd2,
      OP_FLT  = 3'd3,
      OP_FLE  = 3'd4,
      OP_FMIN = 3'd5,
      OP_FMAX = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF   = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF   = 32'hFF80_0000;

   localparam int FFLAG_NV = 4;
   localparam int FFLAG_DZ = 3;
   localparam int FFLAG_OF = 2;
   localparam int FFLAG_UF = 1;
   localparam int FFLAG_NX = 0;

endpackage

// File: rtl/fpu_addsub_issue_if.sv
// Dispatch, writeback and FP-unit signals of the add/sub issue stage.
interface fpu_addsub_issue_if
   import fpu_pkg::*;
#(
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   op_e              in_op;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [TAG_W-1:0] in_tag;

   logic [31:0]      fu_a;
   logic [31:0]      fu_b;
   logic             fu_sub;
   logic             fu_comp;
   logic [31:0]      fu_y;
   logic             fu_a_hi_b;
   logic             fu_a_equal_b;

   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic [4:0]       out_fflags;

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_tag,
      input  fu_y, fu_a_hi_b, fu_a_equal_b, out_ready,
      output in_ready, fu_a, fu_b, fu_sub, fu_comp,
      output out_valid, out_data, out_tag, out_fflags
   );

   modport master (
      output in_valid, in_op, in_a, in_b, in_tag,
      output fu_y, fu_a_hi_b, fu_a_equal_b, out_ready,
      input  in_ready, fu_a, fu_b, fu_sub, fu_comp,
      input  out_valid, out_data, out_tag, out_fflags
   );
endinterface

// File: rtl/fpu_classify.sv
// Single-precision operand classifier; signalling-NaN and infinity outputs
// exist only when FPU_ISSUE_FFLAGS_EN is defined.
module fpu_classify
   import fpu_pkg::*;
(
   input  logic [30:0] mag,
   output logic        is_nan,
   output logic        is_zero
`ifdef FPU_ISSUE_FFLAGS_EN
   ,
   output logic        is_snan,
   output logic        is_inf
`endif
);

   assign is_nan  = (mag[30:23] == 8'hFF) && (mag[22:0] != 23'd0);
   assign is_zero = (mag == 31'd0);

`ifdef FPU_ISSUE_FFLAGS_EN
   assign is_snan = is_nan && !mag[22];
   assign is_inf  = (mag == POS_INF[30:0]);
`endif

endmodule

// File: rtl/fpu_addsub_issue.sv
// Issue/retire stage around the FP add/sub/compare unit.
// Optional exception flags: define FPU_ISSUE_FFLAGS_EN.
//
// state  | meaning
// S_IDLE | no op held, ready to accept
// S_BUSY | operands driven to the unit, counting LAT cycles
// S_DONE | formatted result presented, waiting for out_ready
module fpu_addsub_issue
   import fpu_pkg::*;
#(
   parameter int LAT   = 1,
   parameter int TAG_W = 5
)(
   input  logic               clock,
   input  logic               reset,
   fpu_addsub_issue_if.slave  io
);

   localparam logic [3:0] LAST = 4'(LAT - 1);

   state_e           state;
   logic [3:0]       count;
   op_e              op_q;
   logic [31:0]      a_q, b_q;
   logic [TAG_W-1:0] tag_q;
   logic             sub_q, comp_q;
   logic [31:0]      data_q;
   logic [TAG_W-1:0] otag_q;

   logic a_nan, b_nan, a_zero, b_zero;
   logic any_nan, both_zero, eq, hi, sel_hi, accept;
   logic [31:0] res_data;
   logic [4:0]  res_flags;

`ifdef FPU_ISSUE_FFLAGS_EN
   logic a_snan, b_snan, a_inf, b_inf, inf_clash;
   logic [4:0] fflags_q;

   fpu_classify u_cls_a (.mag(a_q[30:0]), .is_nan(a_nan), .is_zero(a_zero),
                         .is_snan(a_snan), .is_inf(a_inf));
   fpu_classify u_cls_b (.mag(b_q[30:0]), .is_nan(b_nan), .is_zero(b_zero),
                         .is_snan(b_snan), .is_inf(b_inf));
`else
   fpu_classify u_cls_a (.mag(a_q[30:0]), .is_nan(a_nan), .is_zero(a_zero));
   fpu_classify u_cls_b (.mag(b_q[30:0]), .is_nan(b_nan), .is_zero(b_zero));
`endif

   assign io.in_ready = (state == S_IDLE) || ((state == S_DONE) && io.out_ready);
   assign accept      = io.in_valid && io.in_ready;
   assign io.out_valid = (state == S_DONE);
   assign io.fu_a     = a_q;
   assign io.fu_b     = b_q;
   assign io.fu_sub   = sub_q;
   assign io.fu_comp  = comp_q;
   assign io.out_data = data_q;
   assign io.out_tag  = otag_q;

   // The unit may report +0/-0 as ordered; treat them as equal here.
   assign any_nan   = a_nan || b_nan;
   assign both_zero = a_zero && b_zero;
   assign eq        = io.fu_a_equal_b || both_zero;
   assign hi        = io.fu_a_hi_b && !both_zero;
   assign sel_hi    = hi || (eq && !a_q[31]);

   always_comb begin
      res_data = 32'd0;
      case (op_q)
         OP_FADD, OP_FSUB: res_data = io.fu_y;
         OP_FEQ:           res_data = {31'd0, !any_nan && eq};
         OP_FLT:           res_data = {31'd0, !any_nan && !hi && !eq};
         OP_FLE:           res_data = {31'd0, !any_nan && !hi};
         OP_FMIN, OP_FMAX: begin
            if (a_nan && b_nan)                   res_data = CANON_NAN;
            else if (a_nan)                       res_data = b_q;
            else if (b_nan)                       res_data = a_q;
            else if (sel_hi ^ (op_q == OP_FMAX))  res_data = b_q;
            else                                  res_data = a_q;
         end
         default:          res_data = 32'd0;
      endcase
   end

`ifdef FPU_ISSUE_FFLAGS_EN
   // Invalid add: infinities of opposite effective sign.
   assign inf_clash = a_inf && b_inf && ((a_q[31] ^ b_q[31]) ^ (op_q == OP_FSUB));

   always_comb begin
      res_flags = 5'd0;
      case (op_q)
         OP_FADD, OP_FSUB:         res_flags[FFLAG_NV] = inf_clash;
         OP_FLT, OP_FLE:           res_flags[FFLAG_NV] = any_nan;
         OP_FEQ, OP_FMIN, OP_FMAX: res_flags[FFLAG_NV] = a_snan || b_snan;
         default:                  res_flags[FFLAG_NV] = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                      fflags_q <= 5'd0;
      else if ((state == S_BUSY) && (count == LAST))   fflags_q <= res_flags;
   end

   assign io.out_fflags = fflags_q;
`else
   assign res_flags     = 5'd0;
   assign io.out_fflags = res_flags;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         count  <= 4'd0;
         op_q   <= OP_FADD;
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         tag_q  <= '0;
         sub_q  <= 1'b0;
         comp_q <= 1'b0;
         data_q <= 32'd0;
         otag_q <= '0;
      end else if (accept) begin
         state  <= S_BUSY;
         count  <= 4'd0;
         op_q   <= io.in_op;
         a_q    <= io.in_a;
         b_q    <= io.in_b;
         tag_q  <= io.in_tag;
         sub_q  <= (io.in_op == OP_FSUB);
         comp_q <= (io.in_op >= OP_FEQ) && (io.in_op <= OP_FMAX);
      end else begin
         case (state)
            S_BUSY: begin
               if (count == LAST) begin
                  data_q <= res_data;
                  otag_q <= tag_q;
                  state  <= S_DONE;
               end else begin
                  count <= count + 4'd1;
               end
            end
            S_DONE: if (io.out_ready) state <= S_IDLE;
            default: ;
         endcase
      end
   end

endmodule
